// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC sample scheduler: state encodings,
// counter widths and the helpers that derive MIDSCALE and the sample period.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } sched_state_t;

  localparam int UNDERRUN_W = 16;

  function automatic int calc_period(input int clk_hz, input int rate_hz);
    return clk_hz / rate_hz;
  endfunction

  function automatic int calc_midscale(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/dac_sample_scheduler_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; flush wins
// over push/pop, full refuses push and empty refuses pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  // Storage needs no reset: contents are only visible once count says so.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Releases one buffered sample to the DAC per sample period (IDLE/PRIME/PLAY).
// Define DAC_SCHED_UNDERRUN_CNT_EN to implement the saturating underrun counter.
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int CPU_CLOCK_FREQ = 65_000_000,
  parameter int SAMPLE_RATE    = 48_000,
  parameter int DAC_WIDTH      = 10,
  parameter int FIFO_DEPTH     = 8,
  parameter int PRIME_LEVEL    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DAC_WIDTH-1:0]        in_sample,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DAC_WIDTH-1:0]        dac_code,
  output logic                        dac_load,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        playing,
  output logic [UNDERRUN_W-1:0]       underrun_count,
  output sched_state_t                dbg_state
);

  localparam int PERIOD = calc_period(CPU_CLOCK_FREQ, SAMPLE_RATE);
  localparam int TICK_W = $clog2(PERIOD);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_WIDTH-1:0] MIDSCALE  = DAC_WIDTH'(calc_midscale(DAC_WIDTH));
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(PERIOD - 1);

  sched_state_t         r_state;
  logic [TICK_W-1:0]    r_tick;
  logic [DAC_WIDTH-1:0] r_dac_code;
  logic                 r_dac_load;
  logic                 r_playing;

  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_count_next;
  logic [DAC_WIDTH-1:0] w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_flush;

  // Handshake: a sample transfers on any edge where in_valid && in_ready.
  // in_ready is en && state!=IDLE && !full and never looks at a same-cycle pop.
  assign in_ready     = en && (r_state != IDLE) && !w_full;
  assign w_push       = in_valid && in_ready;
  assign w_tick       = (r_state == PLAY) && (r_tick == TICK_LAST);
  assign w_pop        = en && w_tick && !w_empty;
  assign w_flush      = !en || (r_state == IDLE);
  assign w_count_next = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

  sync_fifo #(
    .WIDTH (DAC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (in_sample),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_dac_code <= MIDSCALE;
      r_dac_load <= 1'b0;
      r_playing  <= 1'b0;
    end else begin
      r_dac_load <= 1'b0;
      if (!en) begin
        r_state    <= IDLE;
        r_tick     <= '0;
        r_dac_code <= MIDSCALE;
        r_playing  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= PRIME;
            r_tick     <= '0;
            r_dac_code <= MIDSCALE;
          end
          PRIME: begin
            r_tick <= '0;
            if (w_count_next >= CW'(PRIME_LEVEL)) begin
              r_state   <= PLAY;
              r_playing <= 1'b1;
            end
          end
          PLAY: begin
            if (w_tick) begin
              r_tick <= '0;
              if (!w_empty) begin
                r_dac_code <= w_head;
                r_dac_load <= 1'b1;
              end else begin
                // Underrun: hold the last code and rebuild the cushion.
                r_state   <= PRIME;
                r_playing <= 1'b0;
              end
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
          default: begin
            r_state   <= IDLE;
            r_playing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dac_code   = r_dac_code;
  assign dac_load   = r_dac_load;
  assign playing    = r_playing;
  assign fifo_count = w_count;
  assign dbg_state  = r_state;

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  logic                  w_underrun;
  logic [UNDERRUN_W-1:0] r_underrun_cnt;

  assign w_underrun = en && w_tick && w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun && (r_underrun_cnt != '1)) begin
      r_underrun_cnt <= r_underrun_cnt + UNDERRUN_W'(1);
    end
  end

  assign underrun_count = r_underrun_cnt;
`else
  assign underrun_count = '0;
`endif

endmodule
